// File: rtl/fir_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
// Shared constants for the stereo FIR datapath: default widths, FSM state
// encoding, output saturation limits, the rounding bias and the channel type.
// Ports: none (package).
// ----------------------------------------------------------------------------
package fir_pkg;

    localparam int DATA_W    = 20;
    localparam int COEF_W    = 16;
    localparam int ACC_W     = 40;
    localparam int COEF_FRAC = 15;
    localparam int TAPS      = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] MAC   = 2'd2;
    localparam logic [1:0] ROUND = 2'd3;

    localparam logic [DATA_W-1:0] SAT_MAX = 20'h7FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 20'h80000;

    // Half an LSB of the output in accumulator units: round-half-up.
    localparam logic [ACC_W-1:0] ROUND_CONST = ACC_W'(1) << (COEF_FRAC - 1);

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } chan_t;

endpackage

// File: rtl/lrck_edge_detect.sv
// ----------------------------------------------------------------------------
// lrck_edge_detect
// Brings the codec word clock into the system clock domain with a two-flop
// synchronizer and compares it against a one-cycle-old copy to produce
// single-cycle edge pulses.
// Ports:
//   clock       in   system clock
//   reset       in   synchronous, active-high; clears all three flops
//   lrck        in   codec word clock, asynchronous
//   rise_pulse  out  one-cycle pulse on a synchronized rising edge
//   fall_pulse  out  one-cycle pulse on a synchronized falling edge
// ----------------------------------------------------------------------------
module lrck_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic lrck,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic sync_a;
    logic sync_b;
    logic lrck_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            sync_a    <= lrck;
            sync_b    <= sync_a;
            lrck_prev <= sync_b;
        end
    end

    // Pulses are valid in the cycle after the second synchronizer flop
    // changes, so the consumer acts on the third clock after the transition.
    // Because the flops clear to 0, lrck held high through reset shows up
    // as a rising edge once reset is released.
    assign rise_pulse = sync_b & ~lrck_prev;
    assign fall_pulse = ~sync_b & lrck_prev;

endmodule

// File: rtl/fir_stereo_mac.sv
// ----------------------------------------------------------------------------
// fir_stereo_mac
// Time-multiplexed stereo FIR. Each lrck edge (rising = left, falling =
// right) shifts the new sample into that channel's delay line, then one
// shared multiplier-accumulator walks all taps against coefficients from an
// external synchronous ROM, rounds, saturates and writes the channel output.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high
//   lrck       in   codec word clock, asynchronous to clock
//   l_in       in   left sample (signed DATA_W)
//   r_in       in   right sample (signed DATA_W)
//   coef_addr  out  coefficient ROM address
//   coef_data  in   ROM data, one clock after coef_addr (signed Q1.15)
//   l_out      out  filtered left sample, registered
//   r_out      out  filtered right sample, registered
//   busy       out  high while a computation is in progress
//   overrun    out  sticky: an lrck edge arrived while busy and was dropped
// ----------------------------------------------------------------------------
module fir_stereo_mac
    import fir_pkg::*;
#(
    parameter int DATA_W    = fir_pkg::DATA_W,
    parameter int COEF_W    = fir_pkg::COEF_W,
    parameter int TAPS      = fir_pkg::TAPS,
    parameter int ACC_W     = fir_pkg::ACC_W,
    parameter int COEF_FRAC = fir_pkg::COEF_FRAC
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     lrck,
    input  logic [DATA_W-1:0]        l_in,
    input  logic [DATA_W-1:0]        r_in,
    output logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic [DATA_W-1:0]        l_out,
    output logic [DATA_W-1:0]        r_out,
    output logic                     busy,
    output logic                     overrun
);

    localparam int AW     = $clog2(TAPS);
    localparam int CW     = AW + 1;          // counter must reach TAPS itself
    localparam int PROD_W = DATA_W + COEF_W;

    // The package limits are written for the default widths; any other
    // width falls back to the generic two's complement extremes.
    localparam logic signed [DATA_W-1:0] OUT_MAX =
        (DATA_W == fir_pkg::DATA_W) ? DATA_W'(SAT_MAX) : {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN =
        (DATA_W == fir_pkg::DATA_W) ? DATA_W'(SAT_MIN) : {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND =
        (ACC_W == fir_pkg::ACC_W && COEF_FRAC == fir_pkg::COEF_FRAC)
            ? ACC_W'(ROUND_CONST) : (ACC_W'(1) << (COEF_FRAC - 1));

    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_W){1'b0}}, OUT_MAX};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_W){1'b1}}, OUT_MIN};

    function automatic logic signed [ACC_W-1:0] round_q(input logic signed [ACC_W-1:0] a);
        return (a + RND) >>> COEF_FRAC;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
        if (v > ACC_MAX) begin
            return OUT_MAX;
        end else if (v < ACC_MIN) begin
            return OUT_MIN;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    logic [1:0]                state;
    chan_t                     chan;
    logic [CW-1:0]             n_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  l_taps [TAPS];
    logic signed [DATA_W-1:0]  r_taps [TAPS];

    logic                      rise_pulse;
    logic                      fall_pulse;
    logic                      edge_seen;

    logic [AW-1:0]             tap_idx;
    logic signed [DATA_W-1:0]  tap_sel;
    logic signed [COEF_W-1:0]  coef_s;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;

    lrck_edge_detect u_edge (
        .clock      (clock),
        .reset      (reset),
        .lrck       (lrck),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    assign edge_seen = rise_pulse | fall_pulse;
    assign busy      = (state != IDLE);
    assign coef_s    = coef_data;

    // In MAC cycle n the ROM returns h[n-1] (address issued last cycle),
    // so the sample paired with it is tap n-1.
    always_comb begin
        tap_idx  = n_cnt[AW-1:0] - AW'(1);
        tap_sel  = (chan == CH_L) ? l_taps[tap_idx] : r_taps[tap_idx];
        prod     = PROD_W'(tap_sel) * PROD_W'(coef_s);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            chan      <= CH_L;
            n_cnt     <= '0;
            acc       <= '0;
            coef_addr <= '0;
            l_out     <= '0;
            r_out     <= '0;
            overrun   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                l_taps[k] <= '0;
                r_taps[k] <= '0;
            end
        end else begin
            // Edges during a computation are dropped; only the flag records them.
            if (edge_seen && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (edge_seen) begin
                        chan  <= rise_pulse ? CH_L : CH_R;
                        state <= LOAD;
                    end
                end

                // Load: shift the selected delay line, prime the MAC.
                LOAD: begin
                    if (chan == CH_L) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            l_taps[k] <= l_taps[k-1];
                        end
                        l_taps[0] <= l_in;
                    end else begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            r_taps[k] <= r_taps[k-1];
                        end
                        r_taps[0] <= r_in;
                    end
                    acc       <= '0;
                    n_cnt     <= '0;
                    coef_addr <= '0;
                    state     <= MAC;
                end

                // MAC: n = 0 only issues address 0; n = 1..TAPS accumulate.
                MAC: begin
                    if (n_cnt != '0) begin
                        acc <= acc + prod_ext;
                    end
                    coef_addr <= n_cnt[AW-1:0] + AW'(1);
                    if (n_cnt == CW'(TAPS)) begin
                        state <= ROUND;
                    end else begin
                        n_cnt <= n_cnt + CW'(1);
                    end
                end

                // Round/saturate: write only the channel that was computed.
                ROUND: begin
                    if (chan == CH_L) begin
                        l_out <= sat_data(round_q(acc));
                    end else begin
                        r_out <= sat_data(round_q(acc));
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
